// File: rtl/toggle_gen_pkg.sv
// toggle_gen_pkg: shared types, limits and sizing helper for the toggle_gen slice.
// Optional edge-pulse outputs are controlled by macro TOGGLE_GEN_EDGE_EN.
package toggle_gen_pkg;

   // Largest supported number of cycles per output level
   localparam int unsigned HALF_PERIOD_MAX = 65536;

   // One output level of the square wave
   typedef logic level_t;

   // Counter width needed to hold 0..hp-1, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned hp);
      int unsigned w;
      w = $clog2(hp);
      return (w < 1) ? 1 : w;
   endfunction

endpackage : toggle_gen_pkg

// File: rtl/toggle_gen_if.sv
// toggle_gen_if: output bundle of the square-wave generator.
// rise/fall members exist only when TOGGLE_GEN_EDGE_EN is defined.
interface toggle_gen_if;
   import toggle_gen_pkg::*;

   level_t out;
`ifdef TOGGLE_GEN_EDGE_EN
   logic   rise;
   logic   fall;

   modport master (output out, output rise, output fall);
   modport slave  (input out, input rise, input fall);
`else
   modport master (output out);
   modport slave  (input out);
`endif

endinterface : toggle_gen_if

// File: rtl/toggle_gen_div.sv
// toggle_gen_div: terminal-count divider; tc is high while cnt sits at HALF_PERIOD-1.
// With HALF_PERIOD=1 the counter stays at zero and tc is permanently high.
module toggle_gen_div
   import toggle_gen_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tc
);

   localparam int unsigned     CNT_W    = cnt_width(HALF_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

   logic [CNT_W-1:0] cnt;

   // Count 0..HALF_PERIOD-1 and wrap to zero; reset restarts the phase
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc = (cnt == CNT_LAST);

endmodule : toggle_gen_div

// File: rtl/toggle_gen.sv
// toggle_gen: free-running 50% duty square wave, period 2*HALF_PERIOD cycles.
// Define TOGGLE_GEN_EDGE_EN to add registered one-cycle rise/fall pulses.
module toggle_gen
   import toggle_gen_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 1,
   parameter level_t      INIT_VAL    = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   toggle_gen_if.master bus
);

   if (HALF_PERIOD < 1) begin : g_bad_hp_low
      $error("toggle_gen: HALF_PERIOD must be at least 1");
   end
   if (HALF_PERIOD > HALF_PERIOD_MAX) begin : g_bad_hp_high
      $error("toggle_gen: HALF_PERIOD exceeds HALF_PERIOD_MAX");
   end

   logic   tc;
   level_t out_q;

   toggle_gen_div #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_div (
      .clk (clk),
      .rst (rst),
      .tc  (tc)
   );

   // Output level flop: load INIT_VAL in reset, invert on each terminal count
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= INIT_VAL;
      end else if (tc) begin
         out_q <= ~out_q;
      end
   end

   assign bus.out = out_q;

`ifdef TOGGLE_GEN_EDGE_EN
   logic rise_q;
   logic fall_q;

   // Edge pulses register alongside out, flagging the direction of the toggle
   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= tc & ~out_q;
         fall_q <= tc & out_q;
      end
   end

   assign bus.rise = rise_q;
   assign bus.fall = fall_q;
`endif

endmodule : toggle_gen

// File: tb/tb_toggle_gen.sv
// tb_toggle_gen: five toggle_gen instances with different parameters, checked by
// a vector table, hand-written corner sequences and a random-reset run against an
// arithmetic reference model (out = INIT ^ floor(k/HP) mod 2, k = edges since reset).
module tb_toggle_gen;

   logic       clk;
   logic [4:0] rst_v;
   logic [4:0] outs;
   int         checks;
   int         failures;
   int         k [5];

   // Instance order in all vectors: [0]=HP1 [1]=HP3 [2]=HP4 [3]=HP2/INIT1 [4]=HP65536
   toggle_gen_if bus_hp1 ();
   toggle_gen_if bus_hp3 ();
   toggle_gen_if bus_hp4 ();
   toggle_gen_if bus_hp2 ();
   toggle_gen_if bus_big ();

   toggle_gen #(.HALF_PERIOD(1), .INIT_VAL(1'b0)) u_hp1 (.clk(clk), .rst(rst_v[0]), .bus(bus_hp1));
   toggle_gen #(.HALF_PERIOD(3), .INIT_VAL(1'b0)) u_hp3 (.clk(clk), .rst(rst_v[1]), .bus(bus_hp3));
   toggle_gen #(.HALF_PERIOD(4), .INIT_VAL(1'b0)) u_hp4 (.clk(clk), .rst(rst_v[2]), .bus(bus_hp4));
   toggle_gen #(.HALF_PERIOD(2), .INIT_VAL(1'b1)) u_hp2 (.clk(clk), .rst(rst_v[3]), .bus(bus_hp2));
   toggle_gen #(.HALF_PERIOD(65536), .INIT_VAL(1'b0)) u_big (.clk(clk), .rst(rst_v[4]), .bus(bus_big));

   assign outs = {bus_big.out, bus_hp2.out, bus_hp4.out, bus_hp3.out, bus_hp1.out};

`ifdef TOGGLE_GEN_EDGE_EN
   logic [4:0] rises;
   logic [4:0] falls;
   assign rises = {bus_big.rise, bus_hp2.rise, bus_hp4.rise, bus_hp3.rise, bus_hp1.rise};
   assign falls = {bus_big.fall, bus_hp2.fall, bus_hp4.fall, bus_hp3.fall, bus_hp1.fall};
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rst;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl [12];

   function automatic int hp_of(input int i);
      case (i)
         0:       return 1;
         1:       return 3;
         2:       return 4;
         3:       return 2;
         default: return 65536;
      endcase
   endfunction

   function automatic logic init_of(input int i);
      return (i == 3) ? 1'b1 : 1'b0;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
      end
   endtask

   // Compare every reset instance against the arithmetic reference
   task automatic model_check();
      logic exp_o;
      logic toggled;
      for (int i = 0; i < 5; i++) begin
         if (k[i] >= 0) begin
            exp_o   = init_of(i) ^ (((k[i] / hp_of(i)) % 2) == 1);
            toggled = (k[i] > 0) && ((k[i] % hp_of(i)) == 0);
            check("model_out", i, 32'(outs[i]), 32'(exp_o));
`ifdef TOGGLE_GEN_EDGE_EN
            check("model_rise", i, 32'(rises[i]), 32'(toggled && exp_o));
            check("model_fall", i, 32'(falls[i]), 32'(toggled && !exp_o));
`else
            if (toggled && 1'b0) checks = checks;
`endif
         end
      end
   endtask

   // Drive one edge with the given reset vector, update the model, then check
   task automatic tick(input logic [4:0] r);
      rst_v = r;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         if (r[i]) k[i] = 0;
         else if (k[i] >= 0) k[i] = k[i] + 1;
      end
      model_check();
   endtask

   initial begin
      logic [4:0] r;
      checks   = 0;
      failures = 0;
      rst_v    = '1;
      for (int i = 0; i < 5; i++) k[i] = -1;

      // Bits: {big, hp2/init1, hp4, hp3, hp1}
      tbl[0]  = '{5'b11111, 5'b01000};
      tbl[1]  = '{5'b11111, 5'b01000};
      tbl[2]  = '{5'b00000, 5'b01001};
      tbl[3]  = '{5'b00000, 5'b00000};
      tbl[4]  = '{5'b00000, 5'b00011};
      tbl[5]  = '{5'b00000, 5'b01110};
      tbl[6]  = '{5'b00000, 5'b01111};
      tbl[7]  = '{5'b00000, 5'b00100};
      tbl[8]  = '{5'b00000, 5'b00101};
      tbl[9]  = '{5'b00000, 5'b01000};
      tbl[10] = '{5'b00000, 5'b01011};
      tbl[11] = '{5'b00000, 5'b00010};

      for (int i = 0; i < 12; i++) begin
         tick(tbl[i].rst);
         check("table_row", i, 32'(outs), 32'(tbl[i].exp));
      end

      // HP=4: run to cnt=2 with out=1, reset one edge, then restart from a clean phase
      for (int i = 0; i < 4; i++) tick(5'b00000);
      check("hp4_pre_reset_high", 0, 32'(bus_hp4.out), 32'(1'b1));
      tick(5'b00100);
      check("hp4_mid_reset", 0, 32'(bus_hp4.out), 32'(1'b0));
      for (int i = 1; i <= 3; i++) begin
         tick(5'b00000);
         check("hp4_after_release_low", i, 32'(bus_hp4.out), 32'(1'b0));
      end
      tick(5'b00000);
      check("hp4_first_toggle", 4, 32'(bus_hp4.out), 32'(1'b1));

      // Random reset pulses on the small instances
      for (int n = 0; n < 400; n++) begin
         r = 5'b00000;
         for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 15) == 0);
         tick(r);
      end

      // HP=65536: first toggle exactly on edge 65536 after release
      tick(5'b10000);
      check("big_in_reset", 0, 32'(bus_big.out), 32'(1'b0));
      for (int n = 1; n <= 65536; n++) begin
         tick(5'b00000);
         if (n == 65535) check("big_before_toggle", n, 32'(bus_big.out), 32'(1'b0));
         if (n == 65536) check("big_first_toggle", n, 32'(bus_big.out), 32'(1'b1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_toggle_gen
